// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and multiplier sequencer state type.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_LUI = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  typedef enum logic [1:0] {MS_IDLE, MS_BUSY, MS_DONE} mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier (low half of product) that borrows the shared
// ALU for one ADD per cycle while alu_own_o is high.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   flush           sync abort back to IDLE
//   req_*           operand handshake (req_ready high only in IDLE)
//   resp_*          result handshake (resp_valid high in DONE)
//   alu_own_o       ALU borrowed this cycle
//   alu_op1/op2/ctrl ALU operands and opcode; alu_out_i is the ALU result
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [DATA_WIDTH-1:0] req_a_i,
  input  logic [DATA_WIDTH-1:0] req_b_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_result_o,
  output logic                  alu_own_o,
  output logic [DATA_WIDTH-1:0] alu_op1_o,
  output logic [DATA_WIDTH-1:0] alu_op2_o,
  output logic [2:0]            alu_ctrl_o,
  input  logic [DATA_WIDTH-1:0] alu_out_i
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  mul_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  alu_own_q, alu_own_d;
  logic [DATA_WIDTH-1:0] alu_op1_q, alu_op1_d;
  logic [DATA_WIDTH-1:0] alu_op2_q, alu_op2_d;

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;

    if (flush_i) begin
      state_d = MS_IDLE;
    end else begin
      unique case (state_q)
        MS_IDLE: begin
          if (req_valid_i) begin
            acc_d    = '0;
            mcand_d  = req_a_i;
            mplier_d = req_b_i;
            count_d  = '0;
            state_d  = (EARLY_EXIT && (req_b_i == '0)) ? MS_DONE : MS_BUSY;
          end
        end
        MS_BUSY: begin
          acc_d    = alu_out_i;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + CNT_W'(1);
          // Early exit once no set multiplier bits remain after this step
          if ((count_q == CNT_LAST) || (EARLY_EXIT && ((mplier_q >> 1) == '0))) begin
            state_d = MS_DONE;
          end
        end
        MS_DONE: begin
          if (resp_ready_i) state_d = MS_IDLE;
        end
        default: state_d = MS_IDLE;
      endcase
    end

    // Outputs are registered from the next-state view so they line up with state_q
    req_ready_d  = (state_d == MS_IDLE);
    resp_valid_d = (state_d == MS_DONE);
    alu_own_d    = (state_d == MS_BUSY);
    alu_op1_d    = alu_own_d ? acc_d : '0;
    alu_op2_d    = (alu_own_d && mplier_d[0]) ? mcand_d : '0;
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= MS_IDLE;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      count_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      alu_own_q    <= 1'b0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      count_q      <= count_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      alu_own_q    <= alu_own_d;
      alu_op1_q    <= alu_op1_d;
      alu_op2_q    <= alu_op2_d;
    end
  end

  assign req_ready_o   = req_ready_q;
  assign resp_valid_o  = resp_valid_q;
  assign resp_result_o = acc_q;
  assign alu_own_o     = alu_own_q;
  assign alu_op1_o     = alu_op1_q;
  assign alu_op2_o     = alu_op2_q;
  assign alu_ctrl_o    = ALU_ADD;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: instance 0 with early exit, instance 1 without.
module tb_alu_mul_seq;
  import alu_pkg::*;

  typedef struct {
    int          dut;
    logic [31:0] res;
    int          k;
    int          t;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        req_valid   [2];
  logic        req_ready   [2];
  logic [31:0] req_a       [2];
  logic [31:0] req_b       [2];
  logic        resp_valid  [2];
  logic        resp_ready  [2];
  logic [31:0] resp_result [2];
  logic        alu_own     [2];
  logic [31:0] alu_op1     [2];
  logic [31:0] alu_op2     [2];
  logic [2:0]  alu_ctrl    [2];
  logic [31:0] alu_out     [2];

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_mul_seq #(.DATA_WIDTH(32), .EARLY_EXIT(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_a_i(req_a[0]), .req_b_i(req_b[0]),
    .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]),
    .resp_result_o(resp_result[0]), .alu_own_o(alu_own[0]),
    .alu_op1_o(alu_op1[0]), .alu_op2_o(alu_op2[0]),
    .alu_ctrl_o(alu_ctrl[0]), .alu_out_i(alu_out[0]));

  alu_mul_seq #(.DATA_WIDTH(32), .EARLY_EXIT(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_a_i(req_a[1]), .req_b_i(req_b[1]),
    .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]),
    .resp_result_o(resp_result[1]), .alu_own_o(alu_own[1]),
    .alu_op1_o(alu_op1[1]), .alu_op2_o(alu_op2[1]),
    .alu_ctrl_o(alu_ctrl[1]), .alu_out_i(alu_out[1]));

  // Shared ALU model
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_SLL: return a << b[4:0];
      ALU_LUI: return b;
      ALU_XOR: return a ^ b;
      ALU_SRL: return a >> b[4:0];
      ALU_OR:  return a | b;
      default: return a & b;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < 2; i++) alu_out[i] = alu_f(alu_op1[i], alu_op2[i], alu_ctrl[i]);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: pops the scoreboard on each new response, then checks hold behaviour
  int   own_cnt  [2];
  bit   in_resp  [2];
  bit   ctrl_bad [2];
  exp_t cur      [2];

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        own_cnt[g] = 0; in_resp[g] = 1'b0; ctrl_bad[g] = 1'b0;
      end else begin
        if (req_ready[g]) begin own_cnt[g] = 0; ctrl_bad[g] = 1'b0; end
        if (alu_own[g]) begin
          own_cnt[g]++;
          if (alu_ctrl[g] !== ALU_ADD) ctrl_bad[g] = 1'b1;
        end
        if (resp_valid[g]) begin
          if (!in_resp[g]) begin
            if (exp_q.size() == 0 || exp_q[0].dut != g) begin
              chk($sformatf("unexpected_resp_dut%0d", g), 32'(resp_valid[g]), 32'd0);
            end else begin
              cur[g] = exp_q.pop_front();
              chk($sformatf("result_dut%0d", g), resp_result[g], cur[g].res);
              chk($sformatf("latency_dut%0d", g), 32'(cyc - cur[g].t), 32'(1 + cur[g].k));
              chk($sformatf("own_cycles_dut%0d", g), 32'(own_cnt[g]), 32'(cur[g].k));
              chk($sformatf("ctrl_add_dut%0d", g), 32'(ctrl_bad[g]), 32'd0);
            end
            in_resp[g] = 1'b1;
          end else begin
            chk($sformatf("hold_result_dut%0d", g), resp_result[g], cur[g].res);
            chk($sformatf("req_ready_in_done_dut%0d", g), 32'(req_ready[g]), 32'd0);
          end
        end else begin
          in_resp[g] = 1'b0;
        end
      end
    end
  end

  // Drive one request on an idle instance; optionally register the expectation
  task automatic issue(input int d, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input int k, input bit push);
    int n;
    exp_t e;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("issue_timeout", 32'd1, 32'd0);
    req_a[d] = a; req_b[d] = b; req_valid[d] = 1'b1;
    if (push) begin
      e.dut = d; e.res = res; e.k = k; e.t = cyc;
      exp_q.push_back(e);
    end
    @(negedge clk);
    req_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || req_ready[d] !== 1'b1) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk("drain_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic chk_idle_outputs(input string tag, input int d);
    chk({tag, "_req_ready"},  32'(req_ready[d]),  32'd1);
    chk({tag, "_resp_valid"}, 32'(resp_valid[d]), 32'd0);
    chk({tag, "_alu_own"},    32'(alu_own[d]),    32'd0);
    chk({tag, "_alu_op1"},    alu_op1[d],         32'd0);
    chk({tag, "_alu_op2"},    alu_op2[d],         32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_a[i] = '0; req_b[i] = '0; resp_ready[i] = 1'b1;
    end
    #12;
    chk_idle_outputs("reset0", 0);
    chk("reset0_result", resp_result[0], 32'd0);
    chk_idle_outputs("reset1", 1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Basic products with early exit
    issue(0, 32'd3, 32'd5, 32'd15, 3, 1'b1);                          drain(0);
    issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32, 1'b1);  drain(0);
    issue(0, 32'h1234_5678, 32'd0, 32'd0, 0, 1'b1);                   drain(0);
    issue(0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 2, 1'b1);           drain(0);
    issue(0, 32'h0001_0000, 32'h0001_0000, 32'd0, 17, 1'b1);          drain(0);

    // Fixed-length instance
    issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32, 1'b1);  drain(1);
    issue(1, 32'd3, 32'd5, 32'd15, 32, 1'b1);                         drain(1);
    issue(1, 32'd5, 32'd0, 32'd0, 32, 1'b1);                          drain(1);

    // Consumer stalls five cycles after the result appears
    resp_ready[0] = 1'b0;
    issue(0, 32'd7, 32'd6, 32'd42, 3, 1'b1);
    n = 0;
    while (resp_valid[0] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("stall_wait_timeout", 32'd1, 32'd0);
    repeat (4) @(negedge clk);
    resp_ready[0] = 1'b1;
    drain(0);

    // Flush during the fourth busy cycle
    issue(0, 32'd9, 32'h8000_0001, 32'd0, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("flush_pre_busy", 32'(alu_own[0]), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk_idle_outputs("after_flush", 0);
    repeat (2) @(negedge clk);
    chk("flush_no_resp", 32'(resp_valid[0]), 32'd0);
    issue(0, 32'd2, 32'd3, 32'd6, 2, 1'b1);                           drain(0);

    // A request coincident with flush must be dropped
    flush = 1'b1; req_a[0] = 32'd5; req_b[0] = 32'd5; req_valid[0] = 1'b1;
    @(negedge clk);
    flush = 1'b0; req_valid[0] = 1'b0;
    chk("flush_req_dropped_ready", 32'(req_ready[0]), 32'd1);
    chk("flush_req_dropped_own", 32'(alu_own[0]), 32'd0);
    @(negedge clk);

    // Asynchronous reset in the middle of a busy sequence
    issue(0, 32'd9, 32'h0000_FFFF, 32'd0, 16, 1'b1);
    repeat (2) @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_rst", 0);
    chk("async_rst_result", resp_result[0], 32'd0);
    void'(exp_q.pop_back());
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(0, 32'd10, 32'd10, 32'd100, 4, 1'b1);                       drain(0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
